// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank.
// jk_op_e   : operation selected by the {j,k} pair of one channel.
// jk_next() : next state of a single JK bit, given its current value and the operation.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_e;

    function automatic logic jk_next(input logic q, input jk_op_e op);
        logic nxt;
        case (op)
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK channel.
// Ports: clk, rst_n (async, active-low), j, k, en (JK enable), clr and load
// (synchronous, both ignore en), d (load value).
// Outputs: q (registered state), changed (registered: q moved on the last edge),
// flip (combinational: q will move on the coming edge; used for event counting).
// Parameter RESET_BIT: value q takes while rst_n is low.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    input  logic en,
    input  logic clr,
    input  logic load,
    input  logic d,
    output logic q,
    output logic changed,
    output logic flip
);

    logic q_next;

    // clr beats load beats JK.
    always_comb begin
        q_next = q;
        if (clr)
            q_next = 1'b0;
        else if (load)
            q_next = d;
        else if (en)
            q_next = jk_next(q, jk_op_e'({j, k}));
    end

    assign flip = q_next ^ q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= RESET_BIT;
            changed <= 1'b0;
        end else begin
            q       <= q_next;
            changed <= flip;
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH independent JK flip-flops with a saturating count of bit changes.
// Ports: clk, rst_n (async, active-low), j_i/k_i/en_i (per-channel JK controls),
// clr_i (sync clear of q), load_i/load_data_i (sync parallel load),
// cnt_clr_i (sync clear of event counter and sat flag).
// Outputs: q_o (state), changed_o (per-bit change pulse), event_cnt_o
// (saturating number of bit changes), sat_o (sticky saturation flag).
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j_i,
    input  logic [WIDTH-1:0] k_i,
    input  logic [WIDTH-1:0] en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             cnt_clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] changed_o,
    output logic [CNT_W-1:0] event_cnt_o,
    output logic             sat_o
);

    localparam int POP_W = $clog2(WIDTH + 1);
    // One extra bit so counter + popcount can never wrap before the compare.
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] flip;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .j       (j_i[i]),
            .k       (k_i[i]),
            .en      (en_i[i]),
            .clr     (clr_i),
            .load    (load_i),
            .d       (load_data_i[i]),
            .q       (q_o[i]),
            .changed (changed_o[i]),
            .flip    (flip[i])
        );
    end

    // Changes about to happen on this edge, so the count lands with changed_o.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + POP_W'(flip[i]);
    end

    assign sum = SUM_W'(event_cnt_o) + SUM_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_cnt_o <= '0;
            sat_o       <= 1'b0;
        end else if (cnt_clr_i) begin
            event_cnt_o <= '0;
            sat_o       <= 1'b0;
        end else if (sum > CNT_MAX) begin
            event_cnt_o <= {CNT_W{1'b1}};
            sat_o       <= 1'b1;
        end else begin
            event_cnt_o <= sum[CNT_W-1:0];
        end
    end

endmodule
